traffic_light_seq: RTL and testbench
====================================

// Module: traffic_light_seq
// PURPOSE
//  Timed traffic-light sequencer driving one RGB LED. It generalises the static switch-to-colour
//  decoder with four run modes (auto cycle, manual, flashing yellow, off) and pedestrian request.
//  It also adds PWM brightness control. Sits between board switches/buttons and the RGB pins.
// PARAMETERS
//  TICK_DIV     50_000_000  clocks per timing tick (1 s @ 50 MHz); >=2
//  GREEN_TICKS  10          green phase length in ticks; >=1
//  YELLOW_TICKS 3           yellow phase length in ticks; >=1
//  RED_TICKS    10          red phase length in ticks; >=1
//  MIN_GREEN    4           ticks of green before a pedestrian request may cut it; 1..GREEN_TICKS
//  FLASH_TICKS  1           ticks per on/off half-period in FLASH mode; >=1
//  PWM_BITS     8           brightness resolution
// PORTS
//  clk_i      in  1         system clock
//  rst_i      in  1         asynchronous reset, active-high
//  mode_i     in  2         00 AUTO, 01 MANUAL, 10 FLASH, 11 OFF
//  sw_i       in  2         MANUAL colour select; uses the shared colour codes `WHITE/`RED/`GREEN/`YELLOW
//  ped_req_i  in  1         pedestrian request, level; sampled every clock
//  duty_i     in  PWM_BITS  brightness; 0 = dark, all-ones = fully on
//  rgb_o      out 3         LED drive; bit order per `R_POS/`G_POS/`B_POS
//  state_o    out 2         AUTO phase: 00 GREEN, 01 YELLOW, 10 RED (held while not in AUTO)
//  ped_ack_o  out 1         high while a pedestrian request is latched
// BEHAVIOUR
//  Reset (async assert, sync release): rgb_o=000, state_o=RED, ped_ack_o=0.
//   All counters are 0. Flash phase is off. The registered mode is AUTO.
//  Tick: prescaler counts 0..TICK_DIV-1 and wraps. tick is a 1-clock pulse on the wrap cycle.
//   The prescaler runs in all modes and is never cleared by a mode change.
//  mode_i is registered once (mode_q).
//   When mode_q changes to AUTO, the FSM reloads to RED with phase count 0 on the next clock.
//  AUTO FSM: phase counter increments on tick.
//   RED->GREEN when count==RED_TICKS-1 and tick.
//   GREEN->YELLOW when count==GREEN_TICKS-1 and tick, or when the ped latch is set,
//    count>=MIN_GREEN-1, and tick.
//   YELLOW->RED when count==YELLOW_TICKS-1 and tick.
//   Every transition clears the count to 0.
//  Ped latch: set when ped_req_i=1 and mode_q is AUTO.
//   Cleared on entry to RED; also cleared when leaving AUTO.
//   If set and clear coincide, clear wins. Requests during RED are ignored.
//  MANUAL: colour = sw_i decode (WHITE=111, RED, GREEN, YELLOW=R+G); the FSM is frozen.
//  FLASH: colour = YELLOW when the flash phase is on, else 000.
//   The phase toggles every FLASH_TICKS ticks. The phase is forced off on entering FLASH.
//  OFF: colour = 000.
//  PWM: PWM_BITS counter, free-running every clock.
//   pwm_on = (pwm_cnt < duty_i) | (&duty_i).
//  rgb_o is registered: colour & {3{pwm_on}}. There is 1 clock latency from the state/mode register.
//   No combinational path from inputs to outputs.
//  state_o and ped_ack_o are registered FSM/latch values.
// TESTING
//  (Bench uses TICK_DIV=4, G/Y/R=3/2/3, MIN_GREEN=2, duty_i=FF.)
//  1. Reset release in AUTO -> rgb_o=R for 12 clk, G for 12, Y for 8, R again; state_o 10,00,01,10.
//  2. ped_req_i pulse at green tick 0 -> ped_ack_o=1; green ends after 2 ticks (8 clk) -> YELLOW.
//     ped_ack_o=0 on RED entry.
//  3. MANUAL sw_i=`WHITE/`RED/`GREEN/`YELLOW -> rgb_o 111/R/G/R+G one clock after registration.
//     state_o unchanged.
//  4. FLASH, FLASH_TICKS=1 -> rgb_o alternates 000 and R+G every 4 clk, starting 000.
//     Back to AUTO -> restarts at RED.
//  5. AUTO RED, duty_i=40 (PWM_BITS=8) -> rgb_o R asserted 64 of every 256 clk.
//     duty_i=00 -> never asserted.
//  6. rst_i asserted mid-GREEN off-edge -> rgb_o=000 immediately, state_o=RED; sequence restarts on release.

Source files
------------

// File: rtl/traffic_light_seq.sv
// Timed traffic-light sequencer for one RGB LED.
// Four run modes (AUTO cycle, MANUAL colour select, FLASH yellow, OFF), a latched
// pedestrian request that may shorten green, and PWM brightness on the LED drive.
// rgb_o is bit-ordered R/G/B = [2]/[1]/[0]; MANUAL codes are 00 WHITE, 01 RED,
// 10 GREEN, 11 YELLOW.
module traffic_light_seq #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int GREEN_TICKS  = 10,
  parameter int YELLOW_TICKS = 3,
  parameter int RED_TICKS    = 10,
  parameter int MIN_GREEN    = 4,
  parameter int FLASH_TICKS  = 1,
  parameter int PWM_BITS     = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          mode_i,
  input  logic [1:0]          sw_i,
  input  logic                ped_req_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic [2:0]          rgb_o,
  output logic [1:0]          state_o,
  output logic                ped_ack_o
);

  // LED bit positions and the colours built from them
  localparam int R_POS = 2;
  localparam int G_POS = 1;
  localparam int B_POS = 0;
  localparam logic [2:0] RGB_RED    = 3'(1 << R_POS);
  localparam logic [2:0] RGB_GREEN  = 3'(1 << G_POS);
  localparam logic [2:0] RGB_BLUE   = 3'(1 << B_POS);
  localparam logic [2:0] RGB_YELLOW = RGB_RED | RGB_GREEN;
  localparam logic [2:0] RGB_WHITE  = RGB_RED | RGB_GREEN | RGB_BLUE;

  // MANUAL switch codes
  localparam logic [1:0] SW_WHITE  = 2'b00;
  localparam logic [1:0] SW_RED    = 2'b01;
  localparam logic [1:0] SW_GREEN  = 2'b10;
  localparam logic [1:0] SW_YELLOW = 2'b11;

  // Counter widths; phase counter must hold the longest phase minus one
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (GREEN_TICKS > RED_TICKS)
                          ? ((GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS)
                          : ((RED_TICKS > YELLOW_TICKS) ? RED_TICKS : YELLOW_TICKS);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int FL_W   = $clog2(FLASH_TICKS + 1);

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_RED    = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    M_AUTO   = 2'b00,
    M_MANUAL = 2'b01,
    M_FLASH  = 2'b10,
    M_OFF    = 2'b11
  } mode_e;

  logic [PRE_W-1:0]    presc_q;
  logic [PWM_BITS-1:0] pwm_q;
  mode_e               mode_q, mode_prev_q;
  state_e              state_q, state_d;
  logic [PH_W-1:0]     count_q, count_d;
  logic                ped_q, ped_d;
  logic                flash_on_q, flash_on_d;
  logic [FL_W-1:0]     flash_cnt_q, flash_cnt_d;
  logic [2:0]          rgb_q, rgb_d;

  logic       tick;
  logic       enter_auto;
  logic       red_entry;
  logic       pwm_on;
  logic [2:0] colour;

  assign tick       = (presc_q == PRE_W'(TICK_DIV - 1));
  // FSM reload happens one clock after the registered mode becomes AUTO
  assign enter_auto = (mode_q == M_AUTO) && (mode_prev_q != M_AUTO);

  // Free-running timing prescaler and PWM counter, untouched by mode changes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      pwm_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      pwm_q   <= pwm_q + 1'b1;
    end
  end

  // Registered mode plus its previous value for entry detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q      <= M_AUTO;
      mode_prev_q <= M_AUTO;
    end else begin
      mode_q      <= mode_e'(mode_i);
      mode_prev_q <= mode_q;
    end
  end

  // AUTO phase sequencing; frozen whenever the registered mode is not AUTO
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (enter_auto) begin
      state_d = ST_RED;
      count_d = '0;
    end else if (mode_q == M_AUTO && tick) begin
      count_d = count_q + 1'b1;
      case (state_q)
        ST_RED: begin
          if (count_q == PH_W'(RED_TICKS - 1)) begin
            state_d = ST_GREEN;
            count_d = '0;
          end
        end
        ST_GREEN: begin
          if (count_q == PH_W'(GREEN_TICKS - 1) ||
              (ped_q && count_q >= PH_W'(MIN_GREEN - 1))) begin
            state_d = ST_YELLOW;
            count_d = '0;
          end
        end
        ST_YELLOW: begin
          if (count_q == PH_W'(YELLOW_TICKS - 1)) begin
            state_d = ST_RED;
            count_d = '0;
          end
        end
        default: begin
          state_d = ST_RED;
          count_d = '0;
        end
      endcase
    end
  end

  // Pedestrian latch: clearing (RED entry or not in AUTO) beats setting
  always_comb begin
    red_entry = (state_d == ST_RED) && ((state_q != ST_RED) || enter_auto);
    ped_d     = ped_q;
    if (mode_q != M_AUTO || red_entry) begin
      ped_d = 1'b0;
    end else if (ped_req_i && state_q != ST_RED) begin
      ped_d = 1'b1;
    end
  end

  // Flash phase: held off outside FLASH so it always starts dark on entry
  always_comb begin
    flash_on_d  = flash_on_q;
    flash_cnt_d = flash_cnt_q;
    if (mode_q != M_FLASH) begin
      flash_on_d  = 1'b0;
      flash_cnt_d = '0;
    end else if (tick) begin
      if (flash_cnt_q == FL_W'(FLASH_TICKS - 1)) begin
        flash_on_d  = ~flash_on_q;
        flash_cnt_d = '0;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end
  end

  // Colour selection from the registered mode/state, gated by PWM
  always_comb begin
    colour = 3'b000;
    case (mode_q)
      M_AUTO: begin
        case (state_q)
          ST_GREEN:  colour = RGB_GREEN;
          ST_YELLOW: colour = RGB_YELLOW;
          default:   colour = RGB_RED;
        endcase
      end
      M_MANUAL: begin
        case (sw_i)
          SW_WHITE:  colour = RGB_WHITE;
          SW_RED:    colour = RGB_RED;
          SW_GREEN:  colour = RGB_GREEN;
          SW_YELLOW: colour = RGB_YELLOW;
          default:   colour = 3'b000;
        endcase
      end
      M_FLASH: colour = flash_on_q ? RGB_YELLOW : 3'b000;
      default: colour = 3'b000;
    endcase
    pwm_on = (pwm_q < duty_i) | (&duty_i);
    rgb_d  = colour & {3{pwm_on}};
  end

  // State, latch, flash and LED output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RED;
      count_q     <= '0;
      ped_q       <= 1'b0;
      flash_on_q  <= 1'b0;
      flash_cnt_q <= '0;
      rgb_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ped_q       <= ped_d;
      flash_on_q  <= flash_on_d;
      flash_cnt_q <= flash_cnt_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb_o     = rgb_q;
  assign state_o   = state_q;
  assign ped_ack_o = ped_q;

endmodule

// File: tb/tb_traffic_light_seq.sv
// Directed and randomized bench for traffic_light_seq against a tick-counting reference model.
module tb_traffic_light_seq;
  localparam int TD = 4;
  localparam int GT = 3;
  localparam int YT = 2;
  localparam int RT = 3;
  localparam int MG = 2;
  localparam int FT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [1:0] sw;
  logic       ped;
  logic [7:0] duty;
  logic [2:0] rgb;
  logic [1:0] st;
  logic       ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_light_seq #(
    .TICK_DIV(TD), .GREEN_TICKS(GT), .YELLOW_TICKS(YT), .RED_TICKS(RT),
    .MIN_GREEN(MG), .FLASH_TICKS(FT), .PWM_BITS(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sw_i(sw), .ped_req_i(ped),
    .duty_i(duty), .rgb_o(rgb), .state_o(st), .ped_ack_o(ack)
  );

  // Reference model: phase index 0=green 1=yellow 2=red, time counted in whole ticks
  int         phase_len [3] = '{GT, YT, RT};
  logic [2:0] phase_rgb [3] = '{3'b010, 3'b110, 3'b100};
  logic [2:0] sw_rgb    [4] = '{3'b111, 3'b100, 3'b010, 3'b110};

  int         m_clk, m_mode, m_mode_prev, m_phase, m_ticks, m_fticks;
  bit         m_ped, m_flash;
  logic [2:0] m_rgb;

  task automatic model_reset();
    m_clk = 0; m_mode = 0; m_mode_prev = 0; m_phase = 2; m_ticks = 0;
    m_fticks = 0; m_ped = 0; m_flash = 0; m_rgb = 3'b000;
  endtask

  task automatic model_clock();
    bit tick, entering, red_entry, nped, nf, pwm_on;
    int nphase, nticks, nft;
    logic [2:0] col;
    tick      = ((m_clk % TD) == TD - 1);
    entering  = (m_mode == 0) && (m_mode_prev != 0);
    red_entry = entering;
    nphase    = m_phase;
    nticks    = m_ticks;
    if (entering) begin
      nphase = 2;
      nticks = 0;
    end else if (m_mode == 0 && tick) begin
      nticks = m_ticks + 1;
      if (nticks == phase_len[m_phase] || (m_phase == 0 && m_ped && nticks >= MG)) begin
        nphase    = (m_phase + 1) % 3;
        nticks    = 0;
        red_entry = (nphase == 2);
      end
    end
    if (m_mode != 0 || red_entry) nped = 0;
    else if (ped && m_phase != 2) nped = 1;
    else nped = m_ped;
    nf  = m_flash;
    nft = m_fticks;
    if (m_mode != 2) begin
      nf = 0; nft = 0;
    end else if (tick) begin
      nft = m_fticks + 1;
      if (nft == FT) begin
        nf = !m_flash; nft = 0;
      end
    end
    case (m_mode)
      0:       col = phase_rgb[m_phase];
      1:       col = sw_rgb[sw];
      2:       col = m_flash ? 3'b110 : 3'b000;
      default: col = 3'b000;
    endcase
    pwm_on = ((m_clk % 256) < int'(duty)) || (duty == 8'hFF);
    m_rgb  = pwm_on ? col : 3'b000;
    m_phase = nphase; m_ticks = nticks; m_ped = nped; m_flash = nf; m_fticks = nft;
    m_mode_prev = m_mode;
    m_mode = int'(mode);
    m_clk++;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("rgb", 8'(rgb), 8'(m_rgb));
    check("state", 8'(st), 8'(m_phase));
    check("ped_ack", 8'(ack), 8'(m_ped));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rgb", 8'(rgb), 8'h00);
    check("reset_state", 8'(st), 8'h02);
    check("reset_ack", 8'(ack), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int hits;
    logic [2:0] exp_rgb;
    rst = 1'b1; mode = 2'b00; sw = 2'b00; ped = 1'b0; duty = 8'hFF;

    // 1: AUTO sequence from reset, R12 G12 Y8 then R
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      step();
      if (k <= 12) exp_rgb = 3'b100;
      else if (k <= 24) exp_rgb = 3'b010;
      else if (k <= 32) exp_rgb = 3'b110;
      else exp_rgb = 3'b100;
      check("seq_rgb", 8'(rgb), 8'(exp_rgb));
    end

    // 2: pedestrian request at the start of green shortens it to two ticks
    do_reset();
    repeat (12) step();
    ped = 1'b1;
    step();
    ped = 1'b0;
    check("ped_ack_set", 8'(ack), 8'h01);
    repeat (7) step();
    check("ped_yellow", 8'(st), 8'h01);
    repeat (7) step();
    check("ped_ack_hold", 8'(ack), 8'h01);
    step();
    check("ped_red_state", 8'(st), 8'h02);
    check("ped_ack_clear", 8'(ack), 8'h00);

    // 3: MANUAL colour decode, two clocks after sw/mode change
    mode = 2'b01;
    for (int s = 0; s < 4; s++) begin
      sw = 2'(s);
      repeat (2) step();
      check("manual_rgb", 8'(rgb), 8'(sw_rgb[s]));
    end

    // 4: FLASH then back to AUTO restarting at RED
    mode = 2'b10;
    repeat (24) step();
    mode = 2'b00;
    repeat (3) step();
    check("auto_restart", 8'(st), 8'h02);
    step();
    check("auto_restart_rgb", 8'(rgb), 8'h04);

    // 5: PWM duty 0x40 gives 64 of 256, duty 0 gives none
    mode = 2'b01; sw = 2'b01; duty = 8'h40;
    repeat (2) step();
    hits = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (rgb == 3'b100) hits++;
    end
    check("pwm_40", 8'(hits), 8'd64);
    duty = 8'h00;
    step();
    hits = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (rgb != 3'b000) hits++;
    end
    check("pwm_00", 8'(hits), 8'd0);

    // 6: asynchronous reset mid-green
    mode = 2'b00; duty = 8'hFF;
    do_reset();
    repeat (16) step();
    check("pre_rst_green", 8'(st), 8'h00);
    #2;
    rst = 1'b1;
    #1;
    check("async_rgb", 8'(rgb), 8'h00);
    check("async_state", 8'(st), 8'h02);
    do_reset();
    repeat (14) step();

    // Randomized run against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      sw  = 2'($urandom_range(0, 3));
      ped = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       duty = 8'h00;
        1:       duty = 8'($urandom_range(0, 255));
        default: duty = 8'hFF;
      endcase
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
